conv_tap_accumulator: RTL and testbench

Accumulates a fixed number of rounded products from the fixed-point multiplier into one output feature value per window, e.g. the 9 taps of a 3x3 depthwise kernel. It adds a per-channel bias and applies an optional ReLU. It saturates the result back to the activation width and emits a single-cycle valid. It sits directly downstream of the multiplier and consumes its `Mul_result`/`valid` pair without backpressure. Windows may arrive back-to-back.

---
 rtl/conv_tap_accumulator_pkg.sv | 26 ++
 rtl/conv_tap_accumulator_sat_relu_clamp.sv | 39 +++
 rtl/conv_tap_accumulator.sv | 114 +++++++++++
 tb/tb_conv_tap_accumulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_tap_accumulator_pkg.sv
// Shared types and constants for the convolution tap accumulator
// and the fixed-point multiplier that feeds it.
package conv_tap_accumulator_pkg;

    localparam int CTA_BITSIZE   = 14;
    localparam int CTA_FRAC_BITS = 7;
    localparam int CTA_TAPS      = 9;
    localparam int CTA_ACC_BITS  = 26;

    localparam int PROD_W = 2 * CTA_BITSIZE - CTA_FRAC_BITS;

    localparam logic signed [CTA_BITSIZE-1:0] MAX_ACT =
        {1'b0, {(CTA_BITSIZE-1){1'b1}}};
    localparam logic signed [CTA_BITSIZE-1:0] MIN_ACT =
        {1'b1, {(CTA_BITSIZE-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic int prod_width(input int b, input int f);
        return 2 * b - f;
    endfunction

endpackage

// File: rtl/conv_tap_accumulator_sat_relu_clamp.sv
// Optional ReLU followed by signed saturation from the accumulator
// width down to the activation width.
module sat_relu_clamp #(
    parameter int ACC_BITS = 26,
    parameter int OUT_BITS = 14
) (
    input  logic signed [ACC_BITS-1:0] acc,
    input  logic                       relu,
    output logic signed [OUT_BITS-1:0] data,
    output logic                       sat
);

    localparam logic signed [ACC_BITS-1:0] HI =
        {{(ACC_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] LO =
        {{(ACC_BITS-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

    logic signed [ACC_BITS-1:0] v;

    always_comb begin
        v    = acc;
        sat  = 1'b0;
        data = '0;
        // A ReLU clamp to zero never counts as saturation
        if (relu && acc[ACC_BITS-1]) begin
            v = '0;
        end
        if (v > HI) begin
            data = HI[OUT_BITS-1:0];
            sat  = 1'b1;
        end else if (v < LO) begin
            data = LO[OUT_BITS-1:0];
            sat  = 1'b1;
        end else begin
            data = v[OUT_BITS-1:0];
        end
    end

endmodule

// File: rtl/conv_tap_accumulator.sv
// Sums TAPS rounded products plus bias per window, then ReLU and
// saturation to one registered activation with a one-cycle valid.
module conv_tap_accumulator
    import conv_tap_accumulator_pkg::*;
#(
    parameter int bitsize   = CTA_BITSIZE,
    parameter int FRAC_BITS = CTA_FRAC_BITS,
    parameter int TAPS      = CTA_TAPS,
    parameter int ACC_BITS  = CTA_ACC_BITS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic signed [prod_width(bitsize, FRAC_BITS)-1:0] mul_in,
    input  logic                                  mul_valid,
    input  logic signed [bitsize-1:0]             bias,
    input  logic                                  relu_en,
    input  logic                                  clear,
    output logic signed [bitsize-1:0]             data_out,
    output logic                                  out_valid,
    output logic                                  sat_flag,
    output logic                                  busy
);

    localparam int PW = prod_width(bitsize, FRAC_BITS);
    localparam int CW = $clog2(TAPS + 1);
    localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

    state_t                     state, state_n;
    logic [CW-1:0]              cnt, cnt_n;
    logic signed [ACC_BITS-1:0] acc, acc_n;
    logic                       done, done_n;
    logic                       relu_q, relu_n;

    logic signed [ACC_BITS-1:0] mul_sx, bias_sx;
    logic signed [bitsize-1:0]  clamp_data;
    logic                       clamp_sat;

    assign mul_sx  = {{(ACC_BITS-PW){mul_in[PW-1]}}, mul_in};
    assign bias_sx = {{(ACC_BITS-bitsize){bias[bitsize-1]}}, bias};
    assign busy    = (state == ACCUM);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        done_n  = 1'b0;
        relu_n  = relu_q;
        if (clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            acc_n   = '0;
        end else if (mul_valid) begin
            unique case (state)
                IDLE: begin
                    acc_n  = mul_sx + bias_sx;
                    relu_n = relu_en;
                    if (TAPS == 1) begin
                        done_n = 1'b1;
                        cnt_n  = '0;
                    end else begin
                        cnt_n   = CW'(1);
                        state_n = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_n = acc + mul_sx;
                    if (cnt == LAST) begin
                        done_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Output stage reads acc before a back-to-back reload overwrites it
    sat_relu_clamp #(
        .ACC_BITS(ACC_BITS),
        .OUT_BITS(bitsize)
    ) u_clamp (
        .acc (acc),
        .relu(relu_q),
        .data(clamp_data),
        .sat (clamp_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            done      <= 1'b0;
            relu_q    <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            done      <= done_n;
            relu_q    <= relu_n;
            out_valid <= done;
            if (done) begin
                data_out <= clamp_data;
                sat_flag <= clamp_sat;
            end
        end
    end

endmodule

// File: tb/tb_conv_tap_accumulator.sv
// Scoreboard bench for conv_tap_accumulator: a 9-tap and a 1-tap
// instance, directed windows, expectations queued at the last tap.
module tb_conv_tap_accumulator;

    localparam int B  = 14;
    localparam int F  = 7;
    localparam int PW = 2 * B - F;

    typedef struct {
        logic signed [B-1:0] d;
        logic                s;
        int                  c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic signed [PW-1:0] m9 = '0, m1 = '0;
    logic                 v9 = 1'b0, v1 = 1'b0;
    logic signed [B-1:0]  b9 = '0, b1 = '0;
    logic                 r9 = 1'b0, r1 = 1'b0;
    logic                 c9 = 1'b0, c1 = 1'b0;

    logic signed [B-1:0]  d9, d1;
    logic                 ov9, ov1, s9, s1, bz9, bz1;

    exp_t q9[$];
    exp_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_tap_accumulator #(
        .bitsize(B), .FRAC_BITS(F), .TAPS(9), .ACC_BITS(26)
    ) dut9 (
        .clk(clk), .rst(rst), .mul_in(m9), .mul_valid(v9),
        .bias(b9), .relu_en(r9), .clear(c9),
        .data_out(d9), .out_valid(ov9), .sat_flag(s9), .busy(bz9)
    );

    conv_tap_accumulator #(
        .bitsize(B), .FRAC_BITS(F), .TAPS(1), .ACC_BITS(26)
    ) dut1 (
        .clk(clk), .rst(rst), .mul_in(m1), .mul_valid(v1),
        .bias(b1), .relu_en(r1), .clear(c1),
        .data_out(d1), .out_valid(ov1), .sat_flag(s1), .busy(bz1)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitors: pop and compare whenever a DUT presents an output
    always @(negedge clk) begin
        if (rst && ov9) begin
            if (q9.size() == 0) begin
                chk("t9_unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = q9.pop_front();
                chk("t9_data", int'(d9), int'(e.d));
                chk("t9_sat", int'(s9), int'(e.s));
                chk("t9_cycle", cyc, e.c);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ov1) begin
            if (q1.size() == 0) begin
                chk("t1_unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("t1_data", int'(d1), int'(e.d));
                chk("t1_sat", int'(s1), int'(e.s));
                chk("t1_cycle", cyc, e.c);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle9(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            v9 = 1'b0;
            c9 = 1'b0;
        end
    endtask

    task automatic taps9(input logic signed [PW-1:0] m,
                         input logic signed [B-1:0] b,
                         input logic r, input int n, input int gap,
                         input logic push,
                         input logic signed [B-1:0] ed,
                         input logic es);
        for (int i = 0; i < n; i++) begin
            step();
            m9 = m;
            b9 = b;
            r9 = r;
            v9 = 1'b1;
            c9 = 1'b0;
            if (push && i == n - 1) begin
                exp_t e;
                e.d = ed;
                e.s = es;
                e.c = cyc + 2;
                q9.push_back(e);
            end
            for (int g = 0; g < gap; g++) begin
                step();
                v9 = 1'b0;
            end
        end
    endtask

    task automatic tap1(input logic signed [PW-1:0] m,
                        input logic signed [B-1:0] b,
                        input logic signed [B-1:0] ed,
                        input logic es);
        exp_t e;
        step();
        m1 = m;
        b1 = b;
        v1 = 1'b1;
        e.d = ed;
        e.s = es;
        e.c = cyc + 2;
        q1.push_back(e);
        step();
        v1 = 1'b0;
    endtask

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_data9", int'(d9), 0);
        chk("rst_valid9", int'(ov9), 0);
        chk("rst_sat9", int'(s9), 0);
        chk("rst_busy9", int'(bz9), 0);
        chk("rst_data1", int'(d1), 0);
        chk("rst_valid1", int'(ov1), 0);
        chk("rst_sat1", int'(s1), 0);
        #1;
        rst = 1'b1;
        idle9(2);
        chk("post_rst_valid9", int'(ov9), 0);
        chk("post_rst_valid1", int'(ov1), 0);

        taps9(128, 64, 1'b0, 9, 0, 1'b1, 14'sd1216, 1'b0);
        idle9(3);
        taps9(4000, 0, 1'b0, 9, 0, 1'b1, 14'sd8191, 1'b1);
        taps9(-1000, 0, 1'b0, 9, 0, 1'b1, -14'sd8192, 1'b1);
        taps9(-128, 0, 1'b1, 9, 0, 1'b1, 14'sd0, 1'b0);
        idle9(3);

        taps9(128, 0, 1'b0, 9, 0, 1'b1, 14'sd1152, 1'b0);
        taps9(256, 0, 1'b0, 9, 0, 1'b1, 14'sd2304, 1'b0);
        idle9(3);
        taps9(128, 0, 1'b0, 9, 2, 1'b1, 14'sd1152, 1'b0);
        taps9(256, 0, 1'b0, 9, 2, 1'b1, 14'sd2304, 1'b0);
        idle9(3);

        taps9(500, 0, 1'b0, 4, 0, 1'b0, 14'sd0, 1'b0);
        step();
        v9 = 1'b0;
        chk("busy_mid_window", int'(bz9), 1);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        chk("busy_after_rst", int'(bz9), 0);
        taps9(128, 0, 1'b0, 9, 0, 1'b1, 14'sd1152, 1'b0);
        idle9(3);

        taps9(500, 0, 1'b0, 4, 0, 1'b0, 14'sd0, 1'b0);
        step();
        m9 = 500;
        v9 = 1'b1;
        c9 = 1'b1;
        step();
        v9 = 1'b0;
        c9 = 1'b0;
        chk("busy_after_clear", int'(bz9), 0);
        taps9(128, 0, 1'b0, 9, 0, 1'b1, 14'sd1152, 1'b0);
        idle9(3);

        tap1(300, -44, 14'sd256, 1'b0);
        tap1(20000, 0, 14'sd8191, 1'b1);
        tap1(-300, 44, -14'sd256, 1'b0);

        t = 0;
        while ((q9.size() != 0 || q1.size() != 0) && t < 50) begin
            step();
            t++;
        end
        chk("queues_drained", q9.size() + q1.size(), 0);
        idle9(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
